// File: rtl/ce_gen.sv
// ce_gen: multi-channel clock-enable generator driven from clk_sys.
// Each channel produces a single-cycle enable (ce) at a programmable integer
// ratio, plus a mid-period companion enable (ce_n) in integer mode.
// Optional fractional (NCO) mode is built only when CE_GEN_FRAC_EN is defined;
// without it, mode and inc are ignored and every channel divides by div.
// pause and resync are shared across channels: reset > resync > pause > run.
// Outputs are registered, so no input reaches an output combinationally.
module ce_gen #(
  parameter int CHANNELS = 4,
  parameter int DIV_W    = 8,
  parameter int ACC_W    = 16
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      pause,
  input  logic                      resync,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*DIV_W-1:0] div,
  input  logic [CHANNELS*ACC_W-1:0] inc,
  output logic [CHANNELS-1:0]       ce,
  output logic [CHANNELS-1:0]       ce_n
);

`ifndef CE_GEN_FRAC_EN
  // mode and inc are deliberately unused when the fractional path is absent.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{mode, inc};
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_nsh;
    logic             r_ce;
    logic             r_ce_n;
    logic [DIV_W-1:0] w_div;
    logic [DIV_W-1:0] w_ne;
    logic             w_wrap;
    logic             w_mid;
    logic             w_frac;
    logic             w_carry;

    assign w_div = div[g*DIV_W +: DIV_W];

    // A programmed ratio of 0 behaves as divide-by-1.
    assign w_ne = (r_nsh == '0) ? DIV_W'(1) : r_nsh;

    // End of period: the counter has reached Ne-1. r_cnt never exceeds Ne-1
    // because the shadow ratio only changes when the counter wraps to 0.
    assign w_wrap = (r_cnt >= (w_ne - DIV_W'(1)));

    // Half-way point of the period; ratio 1 has no distinct middle.
    assign w_mid = (w_ne >= DIV_W'(2)) && (r_cnt == ((w_ne >> 1) - DIV_W'(1)));

`ifdef CE_GEN_FRAC_EN
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, inc[g*ACC_W +: ACC_W]};
    assign w_frac  = mode[g];
    assign w_carry = w_sum[ACC_W];

    // Phase accumulator: advances only while this channel runs fractional.
    always_ff @(posedge clk_sys) begin
      if (reset || resync) begin
        r_acc <= '0;
      end else if (!pause && w_frac) begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
`else
    assign w_frac  = 1'b0;
    assign w_carry = 1'b0;
`endif

    // Integer counter, shadow ratio and the registered enables.
    always_ff @(posedge clk_sys) begin
      if (reset || resync) begin
        r_cnt  <= '0;
        r_nsh  <= w_div;
        r_ce   <= 1'b0;
        r_ce_n <= 1'b0;
      end else if (pause) begin
        r_ce   <= 1'b0;
        r_ce_n <= 1'b0;
      end else if (w_frac) begin
        r_ce   <= w_carry;
        r_ce_n <= 1'b0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_nsh  <= w_div;
        r_ce   <= 1'b1;
        r_ce_n <= w_mid;
      end else begin
        r_cnt  <= r_cnt + DIV_W'(1);
        r_ce   <= 1'b0;
        r_ce_n <= w_mid;
      end
    end

    assign ce[g]   = r_ce;
    assign ce_n[g] = r_ce_n;
  end

endmodule

// File: tb/tb_ce_gen.sv
// Bench for ce_gen: directed pulse-pattern checks plus randomized stimulus
// against a per-channel behavioural model (period progress / running phase sum).
module tb_ce_gen;
  localparam int CHANNELS = 4;
  localparam int DIV_W    = 8;
  localparam int ACC_W    = 16;
`ifdef CE_GEN_FRAC_EN
  localparam bit FRAC_EN = 1'b1;
`else
  localparam bit FRAC_EN = 1'b0;
`endif

  logic                      clk_sys;
  logic                      reset;
  logic                      pause;
  logic                      resync;
  logic [CHANNELS-1:0]       mode;
  logic [CHANNELS*DIV_W-1:0] div;
  logic [CHANNELS*ACC_W-1:0] inc;
  logic [CHANNELS-1:0]       ce;
  logic [CHANNELS-1:0]       ce_n;

  int n_checks = 0;
  int n_fail   = 0;

  ce_gen #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .ACC_W(ACC_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .pause(pause), .resync(resync),
    .mode(mode), .div(div), .inc(inc), .ce(ce), .ce_n(ce_n)
  );

  // Clock
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------- behavioural model ----------------
  // Integer: progress = edges elapsed in current period, per = its length.
  // Fractional: phase = running sum of inc; a pulse whenever the sum crosses
  // a multiple of 2^ACC_W.
  int unsigned       m_prog  [CHANNELS];
  int unsigned       m_per   [CHANNELS];
  longint unsigned   m_phase [CHANNELS];
  logic [CHANNELS-1:0] exp_ce;
  logic [CHANNELS-1:0] exp_ce_n;

  function automatic int unsigned eff(input logic [DIV_W-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  always @(posedge clk_sys) begin
    for (int c = 0; c < CHANNELS; c++) begin
      logic [DIV_W-1:0] d;
      d = div[c*DIV_W +: DIV_W];
      if (reset || resync) begin
        m_prog[c]   = 0;
        m_phase[c]  = 0;
        m_per[c]    = eff(d);
        exp_ce[c]   = 1'b0;
        exp_ce_n[c] = 1'b0;
      end else if (pause) begin
        exp_ce[c]   = 1'b0;
        exp_ce_n[c] = 1'b0;
      end else if (FRAC_EN && mode[c]) begin
        longint unsigned s_new;
        s_new = m_phase[c] + longint'(inc[c*ACC_W +: ACC_W]);
        exp_ce[c]   = (s_new >> ACC_W) != (m_phase[c] >> ACC_W);
        exp_ce_n[c] = 1'b0;
        m_phase[c]  = s_new;
      end else begin
        int unsigned pn;
        pn = m_prog[c] + 1;
        exp_ce_n[c] = (m_per[c] >= 2) && (pn == m_per[c] / 2);
        if (pn >= m_per[c]) begin
          exp_ce[c] = 1'b1;
          m_prog[c] = 0;
          m_per[c]  = eff(d);
        end else begin
          exp_ce[c] = 1'b0;
          m_prog[c] = pn;
        end
      end
    end
    #1;
    n_checks++;
    if (ce !== exp_ce || ce_n !== exp_ce_n) begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL model_cmp t=%0t ce=%b ce_n=%b required ce=%b ce_n=%b",
                 $time, ce, ce_n, exp_ce, exp_ce_n);
    end
  end

  // ---------------- directed capture helpers ----------------
  logic [CHANNELS-1:0] h_ce  [0:16];
  logic [CHANNELS-1:0] h_cen [0:16];
  logic [CHANNELS-1:0] h_m   [0:16];

  task automatic step(input int e);
    @(posedge clk_sys);
    #2;
    h_ce[e]  = ce;
    h_cen[e] = ce_n;
    h_m[e]   = exp_ce;
  endtask

  task automatic do_resync();
    @(posedge clk_sys);
    #2;
    resync = 1'b1;
    @(posedge clk_sys);
    #2;
    resync = 1'b0;
  endtask

  // which: 0 = DUT ce, 1 = DUT ce_n, 2 = model ce; bit e-1 is edge e
  function automatic logic [15:0] mask(input int c, input int which);
    logic [15:0] m;
    m = '0;
    for (int e = 1; e <= 16; e++) begin
      case (which)
        0:       m[e-1] = h_ce[e][c];
        1:       m[e-1] = h_cen[e][c];
        default: m[e-1] = h_m[e][c];
      endcase
    end
    return m;
  endfunction

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", nm, act, req);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b1;
    pause  = 1'b0;
    resync = 1'b0;
    mode   = '0;
    inc    = '0;
    div    = {8'd8, 8'd1, 8'd2, 8'd4};
    repeat (3) @(posedge clk_sys);
    #2;
    reset = 1'b0;

    // Reset release, div = {4,2,1,8} on ch0..ch3
    for (int e = 1; e <= 16; e++) step(e);
    check16("rst_ch0_ce",    mask(0, 0), 16'h8888);
    check16("rst_ch0_ce_n",  mask(0, 1), 16'h2222);
    check16("rst_ch1_ce",    mask(1, 0), 16'hAAAA);
    check16("rst_ch1_ce_n",  mask(1, 1), 16'h5555);
    check16("rst_ch2_ce",    mask(2, 0), 16'hFFFF);
    check16("rst_ch2_ce_n",  mask(2, 1), 16'h0000);
    check16("rst_ch3_ce",    mask(3, 0), 16'h8080);
    check16("rst_ch3_ce_n",  mask(3, 1), 16'h0808);
    check16("model_ch0_ce",  mask(0, 2), 16'h8888);
    check16("model_ch3_ce",  mask(3, 2), 16'h8080);

    // ch0 ratio 4 -> 6 two edges after a pulse
    for (int e = 1; e <= 16; e++) begin
      step(e);
      if (e == 2) div[0 +: DIV_W] = 8'd6;
    end
    check16("divchg_ch0_ce",    mask(0, 0), 16'h8208);
    check16("divchg_model_ce",  mask(0, 2), 16'h8208);

    // Pause for 3 cycles starting where the ch0 pulse is due (edge 8)
    div[0 +: DIV_W] = 8'd4;
    do_resync();
    for (int e = 1; e <= 16; e++) begin
      step(e);
      if (e == 7)  pause = 1'b1;
      if (e == 10) pause = 1'b0;
    end
    check16("pause_ch0_ce",    mask(0, 0), 16'h4408);
    check16("pause_model_ce",  mask(0, 2), 16'h4408);

    // Resync together with pause on the edge where ch0 would pulse (edge 4)
    do_resync();
    for (int e = 1; e <= 16; e++) begin
      step(e);
      if (e == 3) begin resync = 1'b1; pause = 1'b1; end
      if (e == 4) begin resync = 1'b0; pause = 1'b0; end
    end
    check16("rsp_ch0_ce",    mask(0, 0), 16'h8880);
    check16("rsp_model_ce",  mask(0, 2), 16'h8880);

`ifdef CE_GEN_FRAC_EN
    begin
      int cnt [CHANNELS];
      int cen_cnt;
      mode = '1;
      inc  = {16'hFFFF, 16'h5555, 16'h0000, 16'h4000};
      do_resync();
      for (int e = 1; e <= 16; e++) step(e);
      check16("frac_ch0_ce",   mask(0, 0), 16'h8888);
      check16("frac_ch0_ce_n", mask(0, 1), 16'h0000);
      check16("frac_ch1_ce",   mask(1, 0), 16'h0000);
      do_resync();
      for (int c = 0; c < CHANNELS; c++) cnt[c] = 0;
      cen_cnt = 0;
      for (int e = 1; e <= 3072; e++) begin
        @(posedge clk_sys);
        #2;
        for (int c = 0; c < CHANNELS; c++) begin
          cnt[c] += int'(ce[c]);
          cen_cnt += int'(ce_n[c]);
        end
      end
      check_int("frac_cnt_4000", cnt[0], 768);
      check_int("frac_cnt_0000", cnt[1], 0);
      check_int("frac_cnt_5555", cnt[2], 1023);
      check_int("frac_cnt_ffff", cnt[3], 3071);
      check_int("frac_ce_n_cnt", cen_cnt, 0);
    end
`else
    mode = '1;
    inc  = {CHANNELS{16'h4000}};
    div  = {CHANNELS{8'd3}};
    do_resync();
    for (int e = 1; e <= 16; e++) step(e);
    for (int c = 0; c < CHANNELS; c++) begin
      check16($sformatf("nofrac_ch%0d_ce", c),   mask(c, 0), 16'h4924);
      check16($sformatf("nofrac_ch%0d_ce_n", c), mask(c, 1), 16'h9249);
    end
`endif

    // Randomized run: ratios (incl. 0), mode flips, increments, pause, resync
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk_sys);
      #2;
      pause  = ($urandom_range(0, 9) == 0);
      resync = ($urandom_range(0, 59) == 0);
      for (int c = 0; c < CHANNELS; c++) begin
        if ($urandom_range(0, 19) == 0)
          div[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 10));
        if ($urandom_range(0, 49) == 0)
          mode[c] = ~mode[c];
        if ($urandom_range(0, 29) == 0) begin
          case ($urandom_range(0, 3))
            0:       inc[c*ACC_W +: ACC_W] = 16'h0000;
            1:       inc[c*ACC_W +: ACC_W] = 16'h4000;
            2:       inc[c*ACC_W +: ACC_W] = 16'hFFFF;
            default: inc[c*ACC_W +: ACC_W] = ACC_W'($urandom_range(0, 65535));
          endcase
        end
      end
    end
    pause  = 1'b0;
    resync = 1'b0;
    repeat (4) @(posedge clk_sys);
    #3;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ce_gen.md
# ce_gen

Parametrised multi-channel clock-enable generator for the emulator top level, replacing the free-running ripple divider and its hand-decoded pixel enable. It derives CHANNELS independent single-cycle enables (video pixel, CPU, audio, …) from clk_sys. Each channel has a programmable integer ratio, an optional mid-period companion enable and an optional fractional (NCO) mode. Pause and resync controls are shared by all channels.

## Interface
- CHANNELS, 4, number of independent enable channels
- DIV_W, 8, width of each integer divide ratio
- ACC_W, 16, width of each fractional phase accumulator / increment
- clk_sys  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  freeze all counters; enables held low
- resync  in  1  one-cycle strobe that realigns all channels to phase 0
- mode  in  CHANNELS  per channel: 0 = integer divide, 1 = fractional
- div  in  CHANNELS*DIV_W  per-channel divide ratio N; channel i at [i*DIV_W +: DIV_W]
- inc  in  CHANNELS*ACC_W  per-channel fractional increment; channel i at [i*ACC_W +: ACC_W]
- ce  out  CHANNELS  single-cycle enable, registered
- ce_n  out  CHANNELS  mid-period enable (integer mode only), registered

## Operation
- Per channel state: cnt[DIV_W], shadow ratio nsh[DIV_W], acc[ACC_W].
- Effective ratio Ne = (nsh == 0) ? 1 : nsh.
- Integer mode, each unpaused edge:
  - If cnt >= Ne-1: cnt <= 0, ce <= 1, and nsh <= div (this is the only point where a new ratio is taken).
  - Otherwise: cnt <= cnt+1, ce <= 0.
  - ce_n <= 1 when Ne >= 2 and cnt == (Ne>>1)-1; otherwise 0.
- Fractional mode, each unpaused edge: {carry, acc} <= acc + inc (ACC_W+1 bits); ce <= carry; ce_n <= 0.
  - Average rate is inc/2^ACC_W. inc = 0 never pulses. Maximum inc = 2^ACC_W-1, which pulses on all but one of every 2^ACC_W cycles.
- Mode change takes effect on the next edge. When mode changes, the counters of the newly selected mode resume from their held values.
- pause = 1: cnt, acc and nsh hold; ce and ce_n <= 0.
- resync = 1: cnt <= 0, acc <= 0, nsh <= div, ce and ce_n <= 0.
- Priority: reset > resync > pause > normal.

## Timing
- Reset values: ce = 0, ce_n = 0, cnt = 0, acc = 0, nsh = div sampled at reset.
- Counting after reset or resync is released (edge 1 is the first edge with both low):
  - Integer ce rises after edge Ne and repeats every Ne edges.
  - Ne = 1 gives ce high continuously from edge 1.
  - ce_n first rises after edge Ne>>1.
- Output latency: one cycle from counter state to ce/ce_n. No combinational path from any input to any output.
- Ratio change mid-period: the current period completes at the old ratio. The new ratio applies from the period starting after the next ce. The first pulse after reset/resync uses div as sampled at that edge.
- Pause:
  - Asserted in cycle k: ce is low after edge k, even if a pulse was due.
  - The pulse that was due is emitted after the first edge with pause = 0; phase is not lost.
- Resync together with a due pulse: the pulse is suppressed; the next pulse arrives Ne edges later.
- Channels are fully independent except for the shared pause/resync.

## Configuration
- CE_GEN_FRAC_EN defined: fractional mode, acc and inc are implemented as described.
- CE_GEN_FRAC_EN undefined:
  - No accumulators are synthesised; mode and inc are ignored.
  - Every channel behaves as integer mode.
  - Port list is unchanged.

## Test plan
- Reset release with div = {4, 2, 1, 8}, integer mode:
  - ch0 ce period 4, first pulse after edge 4.
  - ch1 period 2.
  - ch2 ce constantly high.
  - ch3 ce after edges 8, 16, …; ch3 ce_n after edges 4, 12, ….
  - ch2 ce_n never asserts.
- ch0 div changed 4→6 two edges after a pulse:
  - next pulse still 4 edges after the previous one;
  - subsequent pulses every 6 edges.
- ch0 N = 4, pause held for 3 cycles starting on the cycle the pulse is due:
  - ce stays low throughout the pause;
  - the pulse appears after the first unpaused edge;
  - spacing resumes at 4 with no drift.
- resync asserted on the edge where ch0 (N = 4) would pulse, with pause also high:
  - no pulse;
  - cnt = 0;
  - next pulse 4 edges after resync/pause drop.
- Fractional mode, ACC_W = 16:
  - inc = 0x4000: exactly one ce every 4 edges;
  - inc = 0x5555 over 3·2^16 edges: 65535 pulses (±1);
  - inc = 0: zero pulses; ce_n always 0.
- Build without CE_GEN_FRAC_EN, mode = all-1s, inc = 0x4000, div = 3: ce period 3 on every channel.
